// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: program counter, word-addressed instruction
// memory with a load port, and the IF/ID pipeline register feeding decode.
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   pc,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc4,
  output logic          if_id_valid,
  output logic [5:0]    opcode
);

  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] pc_next;
  logic        redirect;

  // Upper PC bits and the byte offset are ignored, so fetches wrap modulo
  // the memory size.
  assign fetch_word  = mem[pc[AW+1:2]];
  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {if_id_pc4[31:28], jump_index, 2'b00};
  assign redirect    = jump | branch_taken;

  always_comb begin
    pc_next = pc_plus4;
    if (jump)              pc_next = jump_target;
    else if (branch_taken) pc_next = branch_target;
    else if (stall)        pc_next = pc;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) pc <= PC_RESET;
    else       pc <= pc_next;
  end

  // NOTE: the memory array is deliberately left out of reset; program
  // contents survive a reset and the array can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  // A same-cycle write to the fetched index still latches the old word,
  // since the read above sees the array before this edge updates it.
  always_ff @(posedge clk) begin
    if (reset || flush || redirect) begin
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= fetch_word;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

  assign opcode = if_id_instr[31:26];

endmodule
